// File: rtl/id_stage.sv
// RV32I decode stage: 32x32 register file, immediate generation, control decode,
// load-use stall detection and the ID/EX pipeline register.
module id_stage #(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid_ip,
  input  logic [31:0] instr_data_ip,
  input  logic [31:0] instr_pc_addr_ip,
  input  logic        flush_control_ip,
  input  logic        wb_en_ip,
  input  logic [4:0]  wb_rd_ip,
  input  logic [31:0] wb_data_ip,
  output logic        stall_op,
  output logic        ex_valid_op,
  output logic [31:0] ex_pc_op,
  output logic [31:0] ex_rs1_data_op,
  output logic [31:0] ex_rs2_data_op,
  output logic [31:0] ex_imm_op,
  output logic [4:0]  ex_rs1_op,
  output logic [4:0]  ex_rs2_op,
  output logic [4:0]  ex_rd_op,
  output logic [3:0]  ex_alu_op_op,
  output logic        ex_alu_src_op,
  output logic [2:0]  ex_funct3_op,
  output logic        ex_mem_rd_op,
  output logic        ex_mem_wr_op,
  output logic        ex_reg_wr_op,
  output logic        ex_branch_op,
  output logic        ex_jump_op,
  output logic        ex_illegal_op
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  logic [31:0] rf [0:31];

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  arith_op;
  logic [31:0] d_imm;
  logic [3:0]  d_alu_op;
  logic        d_alu_src, d_mem_rd, d_mem_wr, d_reg_wr, d_branch, d_jump, d_illegal;
  logic        use_rs1, use_rs2;
  logic [31:0] rs1_data, rs2_data;
  logic        load_use;

  assign inst   = instr_data_ip;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  // x0 is never stored; writes are held off while reset is asserted.
  always_ff @(posedge clock) begin
    if (reset && wb_en_ip && (wb_rd_ip != 5'd0))
      rf[wb_rd_ip] <= wb_data_ip;
  end

  // inst[30] picks SUB only for register-register ops; SRA applies to both.
  always_comb begin
    arith_op = ALU_ADD;
    case (funct3)
      3'b000:  arith_op = (opcode == OPC_OP && inst[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = inst[30] ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  always_comb begin
    d_imm     = 32'd0;
    d_alu_op  = ALU_ADD;
    d_alu_src = 1'b0;
    d_mem_rd  = 1'b0;
    d_mem_wr  = 1'b0;
    d_reg_wr  = 1'b0;
    d_branch  = 1'b0;
    d_jump    = 1'b0;
    d_illegal = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        d_imm = {{20{inst[31]}}, inst[31:20]};
        d_alu_src = 1'b1; d_mem_rd = 1'b1; d_reg_wr = 1'b1; use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        d_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        d_alu_src = 1'b1; d_mem_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        d_imm = {{20{inst[31]}}, inst[31:20]};
        d_alu_op = arith_op; d_alu_src = 1'b1; d_reg_wr = 1'b1; use_rs1 = 1'b1;
      end
      OPC_OP: begin
        d_alu_op = arith_op; d_reg_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_LUI: begin
        d_imm = {inst[31:12], 12'd0};
        d_alu_op = ALU_PASSB; d_alu_src = 1'b1; d_reg_wr = 1'b1;
      end
      OPC_AUIPC: begin
        d_imm = {inst[31:12], 12'd0};
        d_alu_src = 1'b1; d_reg_wr = 1'b1;
      end
      OPC_BRANCH: begin
        d_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        d_alu_op = ALU_SUB; d_branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_JAL: begin
        d_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        d_alu_src = 1'b1; d_jump = 1'b1; d_reg_wr = 1'b1;
      end
      OPC_JALR: begin
        d_imm = {{20{inst[31]}}, inst[31:20]};
        d_alu_src = 1'b1; d_jump = 1'b1; d_reg_wr = 1'b1; use_rs1 = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // Unused source fields read as index 0 / data 0 so forwarding never matches them.
  always_comb begin
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    if (use_rs1 && (rs1 != 5'd0))
      rs1_data = (WB_BYPASS && wb_en_ip && (wb_rd_ip == rs1)) ? wb_data_ip : rf[rs1];
    if (use_rs2 && (rs2 != 5'd0))
      rs2_data = (WB_BYPASS && wb_en_ip && (wb_rd_ip == rs2)) ? wb_data_ip : rf[rs2];
  end

  assign load_use = ex_valid_op && ex_mem_rd_op && (ex_rd_op != 5'd0) && instr_valid_ip &&
                    ((use_rs1 && (rs1 == ex_rd_op)) || (use_rs2 && (rs2 == ex_rd_op)));
  assign stall_op = load_use && !flush_control_ip;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset || flush_control_ip || load_use) begin
      ex_valid_op    <= 1'b0;
      ex_pc_op       <= 32'd0;
      ex_rs1_data_op <= 32'd0;
      ex_rs2_data_op <= 32'd0;
      ex_imm_op      <= 32'd0;
      ex_rs1_op      <= 5'd0;
      ex_rs2_op      <= 5'd0;
      ex_rd_op       <= 5'd0;
      ex_alu_op_op   <= 4'd0;
      ex_alu_src_op  <= 1'b0;
      ex_funct3_op   <= 3'd0;
      ex_mem_rd_op   <= 1'b0;
      ex_mem_wr_op   <= 1'b0;
      ex_reg_wr_op   <= 1'b0;
      ex_branch_op   <= 1'b0;
      ex_jump_op     <= 1'b0;
      ex_illegal_op  <= 1'b0;
    end else begin
      ex_valid_op    <= instr_valid_ip;
      ex_pc_op       <= instr_pc_addr_ip;
      ex_rs1_data_op <= rs1_data;
      ex_rs2_data_op <= rs2_data;
      ex_imm_op      <= d_imm;
      ex_rs1_op      <= use_rs1 ? rs1 : 5'd0;
      ex_rs2_op      <= use_rs2 ? rs2 : 5'd0;
      ex_rd_op       <= rd;
      ex_alu_op_op   <= d_alu_op;
      ex_alu_src_op  <= d_alu_src;
      ex_funct3_op   <= funct3;
      ex_mem_rd_op   <= d_mem_rd  && instr_valid_ip;
      ex_mem_wr_op   <= d_mem_wr  && instr_valid_ip;
      ex_reg_wr_op   <= d_reg_wr  && instr_valid_ip;
      ex_branch_op   <= d_branch  && instr_valid_ip;
      ex_jump_op     <= d_jump    && instr_valid_ip;
      ex_illegal_op  <= d_illegal && instr_valid_ip;
    end
  end

endmodule
